// File: rtl/vid_pkg.sv
// vid_pkg: shared types and address helpers for the video counter/compare block
package vid_pkg;
  typedef enum logic {MODE_PULSE = 1'b0, MODE_TOGGLE = 1'b1} mode_t;
  function automatic int unsigned period_addr(int unsigned nch);
    return nch;
  endfunction
endpackage

// File: rtl/cmp_chan.sv
// cmp_chan: one compare channel with registered match pulse and toggle level
module cmp_chan
  import vid_pkg::*;
#(
  parameter int WIDTH = 11
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count,
  input  logic             en_eval,
  input  logic             restart,
  input  logic             sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_mode,
  output logic             match,
  output logic             level
);
  logic [WIDTH-1:0] cmp;
  mode_t mode;
  logic hit;
  // compares against the pre-write cmp so a new value takes effect next edge
  assign hit = en_eval && (count == cmp);
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      cmp   <= '1;
      mode  <= MODE_PULSE;
      match <= 1'b0;
      level <= 1'b0;
    end else begin
      if (sel) begin
        cmp  <= wr_data;
        mode <= mode_t'(wr_mode);
      end
      match <= hit;
      level <= (restart || sel || mode == MODE_PULSE) ? 1'b0 : level ^ hit;
    end
  end
endmodule

// File: rtl/vid_cnt_match.sv
// vid_cnt_match: programmable-period video counter shared by NCH equality-decode channels
module vid_cnt_match
  import vid_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int NCH = 4,
  localparam int AW = $clog2(NCH + 1)
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             en,
  input  logic             restart,
  input  logic             wr,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_mode,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic [NCH-1:0]   match,
  output logic [NCH-1:0]   level
);
  logic [WIDTH-1:0] period;
  logic wrap_cond;
  logic en_eval;
  // the all-ones escape keeps a period written below count from locking up
  assign wrap_cond = (count == period) || (count == '1);
  assign en_eval = en && !restart;
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      count  <= '0;
      wrap   <= 1'b0;
      period <= '1;
    end else begin
      if (wr && wr_addr == AW'(period_addr(NCH))) period <= wr_data;
      count <= restart ? '0 : !en ? count : wrap_cond ? '0 : count + 1'b1;
      wrap  <= en_eval && wrap_cond;
    end
  end
  for (genvar i = 0; i < NCH; i++) begin : g_chan
    cmp_chan #(.WIDTH(WIDTH)) u_chan (
      .sys_clk (sys_clk),
      .reset   (reset),
      .count   (count),
      .en_eval (en_eval),
      .restart (restart),
      .sel     (wr && wr_addr == AW'(i)),
      .wr_data (wr_data),
      .wr_mode (wr_mode),
      .match   (match[i]),
      .level   (level[i])
    );
  end
endmodule

// File: tb/tb_vid_cnt_match.sv
// tb_vid_cnt_match: directed self-checking bench for vid_cnt_match (WIDTH=11, NCH=4)
module tb_vid_cnt_match;
  logic        sys_clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        restart = 1'b0;
  logic        wr = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [10:0] wr_data = '0;
  logic        wr_mode = 1'b0;
  logic [10:0] count;
  logic        wrap;
  logic [3:0]  match;
  logic [3:0]  level;
  int tests = 0;
  int fails = 0;

  vid_cnt_match #(.WIDTH(11), .NCH(4)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .en      (en),
    .restart (restart),
    .wr      (wr),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_mode (wr_mode),
    .count   (count),
    .wrap    (wrap),
    .match   (match),
    .level   (level)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write(input logic [2:0] a, input logic [10:0] d, input logic m);
    wr = 1'b1;
    wr_addr = a;
    wr_data = d;
    wr_mode = m;
    step();
    wr = 1'b0;
  endtask

  initial begin
    step();
    step();
    chk("rst_count", 32'(count), 0);
    chk("rst_wrap", 32'(wrap), 0);
    chk("rst_match", 32'(match), 0);
    chk("rst_level", 32'(level), 0);
    reset = 1'b0;
    en = 1'b1;
    // full-range run with reset period and compares at 2047
    for (int k = 1; k <= 2049; k++) begin
      step();
      if (k == 2047 || k == 2048 || k == 2049 || k == 100) begin
        chk("full_count", 32'(count), 32'(k % 2048));
        chk("full_wrap", 32'(wrap), 32'(k == 2048));
        chk("full_match", 32'(match), (k == 2048) ? 32'hF : 32'h0);
      end
    end
    write(3'd4, 11'd9, 1'b0);
    write(3'd0, 11'd3, 1'b0);
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("rs1_count", 32'(count), 0);
    for (int k = 1; k <= 30; k++) begin
      step();
      chk("p9_count", 32'(count), 32'(k % 10));
      chk("p9_wrap", 32'(wrap), 32'(k % 10 == 0));
      chk("p9_match", 32'(match), (k % 10 == 4) ? 32'h1 : 32'h0);
      chk("p9_level", 32'(level), 0);
    end
    write(3'd1, 11'd2, 1'b1);
    write(3'd2, 11'd7, 1'b1);
    restart = 1'b1;
    step();
    restart = 1'b0;
    for (int k = 1; k <= 28; k++) begin
      step();
      chk("tg_count", 32'(count), 32'(k % 10));
      chk("tg_match", 32'(match),
          32'({k % 10 == 8, k % 10 == 3, k % 10 == 4}));
      chk("tg_level", 32'(level),
          32'({((k + 2) / 10) % 2 == 1, ((k + 7) / 10) % 2 == 1, 1'b0}));
    end
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("rs2_count", 32'(count), 0);
    chk("rs2_level", 32'(level), 0);
    chk("rs2_match", 32'(match), 0);
    // write cmp0=5 on the edge where count==5: old cmp0 governs that edge
    for (int k = 1; k <= 5; k++) step();
    chk("col_pre_count", 32'(count), 5);
    write(3'd0, 11'd5, 1'b0);
    chk("col_count", 32'(count), 6);
    chk("col_match0", 32'(match[0]), 0);
    for (int j = 1; j <= 10; j++) begin
      step();
      chk("col_next_count", 32'(count), 32'((6 + j) % 10));
      chk("col_next_match0", 32'(match[0]), 32'(j == 10));
    end
    restart = 1'b1;
    write(3'd4, 11'd2047, 1'b0);
    restart = 1'b0;
    for (int k = 1; k <= 50; k++) step();
    chk("lo_count50", 32'(count), 50);
    write(3'd4, 11'd20, 1'b0);
    chk("lo_count51", 32'(count), 51);
    for (int k = 1; k <= 1996; k++) step();
    chk("lo_count_max", 32'(count), 2047);
    step();
    chk("lo_wrap_count", 32'(count), 0);
    chk("lo_wrap", 32'(wrap), 1);
    for (int k = 1; k <= 20; k++) step();
    chk("p20_count", 32'(count), 20);
    chk("p20_wrap_pre", 32'(wrap), 0);
    step();
    chk("p20_wrap_count", 32'(count), 0);
    chk("p20_wrap", 32'(wrap), 1);
    // en duty 1/0: match pulses stay one cycle wide
    for (int p = 1; p <= 6; p++) begin
      en = 1'b1;
      step();
      chk("duty_count_en", 32'(count), 32'(p));
      chk("duty_match_en", 32'(match[0]), 32'(p == 6));
      en = 1'b0;
      step();
      chk("duty_count_hold", 32'(count), 32'(p));
      chk("duty_match_hold", 32'(match[0]), 0);
      chk("duty_wrap_hold", 32'(wrap), 0);
    end
    en = 1'b1;
    restart = 1'b1;
    write(3'd5, 11'd3, 1'b1);
    restart = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      step();
      chk("bad_addr_count", 32'(count), 32'(k % 21));
      chk("bad_addr_wrap", 32'(wrap), 32'(k == 21));
      chk("bad_addr_match0", 32'(match[0]), 32'(k == 6));
      chk("bad_addr_level0", 32'(level[0]), 0);
    end
    reset = 1'b1;
    write(3'd0, 11'd4, 1'b1);
    reset = 1'b0;
    chk("rst2_count", 32'(count), 0);
    chk("rst2_level", 32'(level), 0);
    chk("rst2_match", 32'(match), 0);
    for (int k = 1; k <= 2048; k++) begin
      step();
      if (k == 5) chk("rst2_match_k5", 32'(match), 0);
      if (k == 30) chk("rst2_count30", 32'(count), 30);
      if (k == 2048) begin
        chk("rst2_match_max", 32'(match), 32'hF);
        chk("rst2_wrap_max", 32'(wrap), 1);
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
